// File: rtl/output_drain.sv
// Output drain: reads result words from the output SRAM one at a time and
// streams each word out as two bytes (low then high) over a valid/ready port.
module output_drain #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int OUT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   count,
  output logic                  sram_re,
  output logic [ADDR_WIDTH-1:0] sram_raddr,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  if (DATA_WIDTH != 2 * OUT_WIDTH) begin : g_width_check
    $error("output_drain: DATA_WIDTH must be exactly 2*OUT_WIDTH");
  end

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    SEND_LO,
    SEND_HI,
    DONE
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] ptr, ptr_nxt;
  logic [ADDR_WIDTH:0]   remaining, remaining_nxt;
  logic [DATA_WIDTH-1:0] hold, hold_nxt;

  // Address wraps explicitly so non-power-of-two depths also stay in range.
  function automatic logic [ADDR_WIDTH-1:0] wrap_inc(input logic [ADDR_WIDTH-1:0] a);
    if (a == ADDR_WIDTH'(DEPTH - 1)) return '0;
    else return a + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      hold      <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      remaining <= remaining_nxt;
      hold      <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    remaining_nxt = remaining;
    hold_nxt      = hold;
    case (state)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            ptr_nxt       = base_addr;
            remaining_nxt = count;
            state_nxt     = READ;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      READ:    state_nxt = WAIT;
      WAIT: begin
        hold_nxt  = sram_rdata;
        state_nxt = SEND_LO;
      end
      SEND_LO: if (out_ready) state_nxt = SEND_HI;
      SEND_HI: begin
        if (out_ready) begin
          remaining_nxt = remaining - 1'b1;
          ptr_nxt       = wrap_inc(ptr);
          state_nxt     = (remaining == (ADDR_WIDTH+1)'(1)) ? DONE : READ;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode registered state only, so reset clears them without a clock.
  always_comb begin
    sram_re    = (state == READ);
    sram_raddr = ptr;
    busy       = (state != IDLE);
    done       = (state == DONE);
    out_valid  = 1'b0;
    out_data   = '0;
    case (state)
      SEND_LO: begin
        out_valid = 1'b1;
        out_data  = hold[OUT_WIDTH-1:0];
      end
      SEND_HI: begin
        out_valid = 1'b1;
        out_data  = hold[DATA_WIDTH-1:OUT_WIDTH];
      end
      default: ;
    endcase
  end

endmodule
